// File: rtl/koa_mul_scheduler_pkg.sv
// Shared types and constants for the KOA multiplier scheduler.
package koa_sched_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/koa_mul_scheduler_if.sv
// Requester, multiplier and response bundle for koa_mul_scheduler.
interface koa_mul_scheduler_if #(
  parameter int SW = 56
);
  logic            req0_valid_i;
  logic            req1_valid_i;
  logic [SW-1:0]   req0_a_i;
  logic [SW-1:0]   req0_b_i;
  logic [SW-1:0]   req1_a_i;
  logic [SW-1:0]   req1_b_i;
  logic            req0_ready_o;
  logic            req1_ready_o;
  logic [SW-1:0]   mul_a_o;
  logic [SW-1:0]   mul_b_o;
  logic            mul_load_o;
  logic [2*SW-1:0] mul_result_i;
  logic            rsp_valid_o;
  logic            rsp_id_o;
  logic [2*SW-1:0] rsp_result_o;
  logic            rsp_ready_i;

  modport slave (
    input  req0_valid_i, req1_valid_i, req0_a_i, req0_b_i, req1_a_i, req1_b_i,
    input  mul_result_i, rsp_ready_i,
    output req0_ready_o, req1_ready_o, mul_a_o, mul_b_o, mul_load_o,
    output rsp_valid_o, rsp_id_o, rsp_result_o
  );

  modport master (
    output req0_valid_i, req1_valid_i, req0_a_i, req0_b_i, req1_a_i, req1_b_i,
    output mul_result_i, rsp_ready_i,
    input  req0_ready_o, req1_ready_o, mul_a_o, mul_b_o, mul_load_o,
    input  rsp_valid_o, rsp_id_o, rsp_result_o
  );
endinterface

// File: rtl/koa_mul_scheduler_arb.sv
// Two-requester grant logic: one-hot grant, ties resolved by the pointer.
module koa_sched_arb (
  input  logic       i_valid0,
  input  logic       i_valid1,
  input  logic       i_ptr,
  input  logic       i_en,
  output logic [1:0] o_grant
);
  always_comb begin
    o_grant = 2'b00;
    if (i_en) begin
      // i_ptr high hands the tie to requester 1
      if (i_valid0 && i_valid1) o_grant = i_ptr ? 2'b10 : 2'b01;
      else                      o_grant = {i_valid1, i_valid0};
    end
  end
endmodule

// File: rtl/koa_mul_scheduler.sv
// Schedules two requesters onto one shared KOA multiplier, one operation at a time.
// Define KOA_SCHED_ROUND_ROBIN_EN for round-robin tie breaking (default: requester 0 wins).
module koa_mul_scheduler
  import koa_sched_pkg::*;
#(
  parameter int SW  = 56,
  parameter int LAT = 2
) (
  input  logic                clk,
  input  logic                rst,
  koa_mul_scheduler_if.slave  bus
);
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [SW-1:0]    r_a;
  logic [SW-1:0]    r_b;
  logic             r_id;
  logic [1:0]       w_grant;
  logic             w_ptr;
  logic             w_arb_en;
  logic             w_accept;

  // Gating with rst keeps both readies low while reset is held
  assign w_arb_en = (r_state == IDLE) && rst;
  assign w_accept = |w_grant;

  koa_sched_arb u_arb (
    .i_valid0 (bus.req0_valid_i),
    .i_valid1 (bus.req1_valid_i),
    .i_ptr    (w_ptr),
    .i_en     (w_arb_en),
    .o_grant  (w_grant)
  );

`ifdef KOA_SCHED_ROUND_ROBIN_EN
  logic r_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          r_ptr <= 1'b0;
    else if (w_accept) r_ptr <= w_grant[0];
  end

  assign w_ptr = r_ptr;
`else
  assign w_ptr = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_id    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_cnt <= CNT_W'(LAT - 1);
        r_a   <= w_grant[1] ? bus.req1_a_i : bus.req0_a_i;
        r_b   <= w_grant[1] ? bus.req1_b_i : bus.req0_b_i;
        r_id  <= w_grant[1];
      end else if ((r_state == BUSY) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    bus.mul_load_o  = 1'b0;
    bus.rsp_valid_o = 1'b0;
    case (r_state)
      IDLE: if (w_accept) w_state_nxt = BUSY;
      BUSY: begin
        if (r_cnt == '0) begin
          bus.mul_load_o = 1'b1;
          w_state_nxt    = DONE;
        end
      end
      DONE: begin
        bus.rsp_valid_o = 1'b1;
        if (bus.rsp_ready_i) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.req0_ready_o = w_grant[0];
  assign bus.req1_ready_o = w_grant[1];
  assign bus.mul_a_o      = r_a;
  assign bus.mul_b_o      = r_b;
  assign bus.rsp_id_o     = r_id;
  assign bus.rsp_result_o = bus.mul_result_i;

endmodule

// File: tb/tb_koa_mul_scheduler.sv
// Directed bench for koa_mul_scheduler: LAT=2 and LAT=1 instances sharing clock and reset.
module tb_koa_mul_scheduler;
  localparam int SW = 56;

  typedef struct {
    logic            v0;
    logic            v1;
    logic [SW-1:0]   a0;
    logic [SW-1:0]   b0;
    logic [SW-1:0]   a1;
    logic [SW-1:0]   b1;
    logic            exp_id;
    logic [2*SW-1:0] exp_res;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [2*SW-1:0] m2;
  logic [2*SW-1:0] m1;

  koa_mul_scheduler_if #(.SW(SW)) bus2 ();
  koa_mul_scheduler_if #(.SW(SW)) bus1 ();

  koa_mul_scheduler #(.SW(SW), .LAT(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));
  koa_mul_scheduler #(.SW(SW), .LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  always #5 clk = ~clk;

  // External multiplier result registers
  always_ff @(posedge clk) begin
    if (bus2.mul_load_o) m2 <= (2*SW)'(bus2.mul_a_o) * (2*SW)'(bus2.mul_b_o);
    if (bus1.mul_load_o) m1 <= (2*SW)'(bus1.mul_a_o) * (2*SW)'(bus1.mul_b_o);
  end
  assign bus2.mul_result_i = m2;
  assign bus1.mul_result_i = m1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v, input string tag);
    int   n;
    logic gid;
    @(negedge clk);
    bus2.req0_valid_i = v.v0;
    bus2.req1_valid_i = v.v1;
    bus2.req0_a_i = v.a0; bus2.req0_b_i = v.b0;
    bus2.req1_a_i = v.a1; bus2.req1_b_i = v.b1;
    bus2.rsp_ready_i = 1'b0;
    #1;
    n = 0;
    while (!(bus2.req0_ready_o || bus2.req1_ready_o) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 20) begin
      chk({tag, "_accept_timeout"}, 0, 1);
      bus2.req0_valid_i = 1'b0;
      bus2.req1_valid_i = 1'b0;
      return;
    end
    chk({tag, "_onehot"}, bus2.req0_ready_o & bus2.req1_ready_o, 0);
    gid = bus2.req1_ready_o;
    chk({tag, "_grant"}, gid, v.exp_id);
    @(negedge clk); #1;
    bus2.req0_valid_i = 1'b0;
    bus2.req1_valid_i = 1'b0;
    chk({tag, "_load_t1"}, bus2.mul_load_o, 0);
    chk({tag, "_ready_busy"}, bus2.req0_ready_o | bus2.req1_ready_o, 0);
    @(negedge clk); #1;
    chk({tag, "_load_t2"}, bus2.mul_load_o, 1);
    chk({tag, "_valid_t2"}, bus2.rsp_valid_o, 0);
    @(negedge clk); #1;
    chk({tag, "_valid_t3"}, bus2.rsp_valid_o, 1);
    chk({tag, "_load_t3"}, bus2.mul_load_o, 0);
    chk({tag, "_id"}, bus2.rsp_id_o, v.exp_id);
    chk({tag, "_result"}, bus2.rsp_result_o, v.exp_res);
    chk({tag, "_mul_a_held"}, bus2.mul_a_o, v.exp_id ? v.a1 : v.a0);
    bus2.rsp_ready_i = 1'b1;
    @(negedge clk); #1;
    chk({tag, "_valid_after_ack"}, bus2.rsp_valid_o, 0);
    bus2.rsp_ready_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t            tbl[4];
    vec_t            v;
    logic [SW-1:0]   ones;
    logic [2*SW-1:0] maxsq;
    logic            seen;
    logic            rr_exp;

    ones  = {SW{1'b1}};
    maxsq = {56'hFFFFFFFFFFFFFE, 56'h00000000000001};

    tbl[0] = '{1'b1, 1'b0, 56'd3,  56'd5,  56'd0, 56'd0, 1'b0, 112'd15};
    tbl[1] = '{1'b0, 1'b1, 56'd0,  56'd0,  56'd7, 56'd9, 1'b1, 112'd63};
    tbl[2] = '{1'b1, 1'b1, 56'd2,  56'd11, 56'd4, 56'd6, 1'b0, 112'd22};
    tbl[3] = '{1'b1, 1'b0, ones,   ones,   56'd0, 56'd0, 1'b0, maxsq};

    bus2.req0_valid_i = 1'b1; bus2.req1_valid_i = 1'b1;
    bus2.req0_a_i = 56'd9; bus2.req0_b_i = 56'd9;
    bus2.req1_a_i = 56'd8; bus2.req1_b_i = 56'd8;
    bus2.rsp_ready_i = 1'b0;
    bus1.req0_valid_i = 1'b0; bus1.req1_valid_i = 1'b0;
    bus1.req0_a_i = '0; bus1.req0_b_i = '0;
    bus1.req1_a_i = '0; bus1.req1_b_i = '0;
    bus1.rsp_ready_i = 1'b0;

    // Reset state, with valids high to show readies stay low
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready0", bus2.req0_ready_o, 0);
    chk("rst_ready1", bus2.req1_ready_o, 0);
    chk("rst_mul_a", bus2.mul_a_o, 0);
    chk("rst_mul_b", bus2.mul_b_o, 0);
    chk("rst_load", bus2.mul_load_o, 0);
    chk("rst_rsp_valid", bus2.rsp_valid_o, 0);
    chk("rst_rsp_id", bus2.rsp_id_o, 0);
    bus2.req0_valid_i = 1'b0; bus2.req1_valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 4; i++) run_op(tbl[i], $sformatf("vec%0d", i));

    // Backpressure: DONE held for 10 cycles
    @(negedge clk);
    bus2.req0_valid_i = 1'b1; bus2.req0_a_i = 56'd12; bus2.req0_b_i = 56'd13;
    #1;
    chk("bp_accept", bus2.req0_ready_o, 1);
    @(negedge clk); bus2.req0_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    bus2.req0_valid_i = 1'b1; bus2.req1_valid_i = 1'b1;
    #1;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("bp_valid_%0d", i), bus2.rsp_valid_o, 1);
      chk($sformatf("bp_result_%0d", i), bus2.rsp_result_o, 156);
      chk($sformatf("bp_readies_%0d", i), {bus2.req1_ready_o, bus2.req0_ready_o}, 0);
      @(negedge clk); #1;
    end
    bus2.req0_valid_i = 1'b0; bus2.req1_valid_i = 1'b0;
    bus2.rsp_ready_i = 1'b1;
    @(negedge clk); #1;
    chk("bp_released", bus2.rsp_valid_o, 0);
    bus2.rsp_ready_i = 1'b0;

    // Reset in the first BUSY cycle, requester 1 owns the operation
    @(negedge clk);
    bus2.req1_valid_i = 1'b1; bus2.req1_a_i = 56'd21; bus2.req1_b_i = 56'd2;
    #1;
    chk("mid_accept", bus2.req1_ready_o, 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_mul_a", bus2.mul_a_o, 0);
    chk("mid_mul_b", bus2.mul_b_o, 0);
    chk("mid_load", bus2.mul_load_o, 0);
    chk("mid_rsp_valid", bus2.rsp_valid_o, 0);
    chk("mid_rsp_id", bus2.rsp_id_o, 0);
    chk("mid_readies", {bus2.req1_ready_o, bus2.req0_ready_o}, 0);
    repeat (2) @(negedge clk);
    bus2.req1_valid_i = 1'b0;
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      if (bus2.rsp_valid_o) seen = 1'b1;
    end
    chk("mid_no_rsp", seen, 0);

    // Simultaneous valids from a fresh pointer
    for (int i = 0; i < 4; i++) begin
`ifdef KOA_SCHED_ROUND_ROBIN_EN
      rr_exp = (i % 2) == 1;
`else
      rr_exp = 1'b0;
`endif
      v.v0 = 1'b1; v.v1 = 1'b1;
      v.a0 = 56'(10 + i); v.b0 = 56'd3;
      v.a1 = 56'(20 + i); v.b1 = 56'd5;
      v.exp_id  = rr_exp;
      v.exp_res = rr_exp ? 112'((20 + i) * 5) : 112'((10 + i) * 3);
      run_op(v, $sformatf("tie%0d", i));
    end

    // LAT=1 with maximum operands
    @(negedge clk);
    bus1.req0_valid_i = 1'b1; bus1.req0_a_i = ones; bus1.req0_b_i = ones;
    #1;
    chk("l1_accept", bus1.req0_ready_o, 1);
    @(negedge clk); #1;
    bus1.req0_valid_i = 1'b0;
    chk("l1_load_t1", bus1.mul_load_o, 1);
    chk("l1_valid_t1", bus1.rsp_valid_o, 0);
    @(negedge clk); #1;
    chk("l1_load_t2", bus1.mul_load_o, 0);
    chk("l1_valid_t2", bus1.rsp_valid_o, 1);
    chk("l1_result", bus1.rsp_result_o, maxsq);
    bus1.rsp_ready_i = 1'b1;
    @(negedge clk); #1;
    chk("l1_released", bus1.rsp_valid_o, 0);
    bus1.rsp_ready_i = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/koa_mul_scheduler.md
KOA_MUL_SCHEDULER -- requirements
Module: koa_mul_scheduler

Interface
REQ-001 The block SHALL have parameter SW, default 56, giving the operand width in bits.
REQ-002 The block SHALL have parameter LAT, default 2, giving the multiplier settle cycles; legal range is 1..15.
REQ-003 clk  input  1  The single clock; all flops are rising-edge.
REQ-004 rst  input  1  Asynchronous, active-low reset.
REQ-005 req0_valid_i / req1_valid_i  input  1  Requester 0/1 has an operand pair.
REQ-006 req0_a_i, req0_b_i / req1_a_i, req1_b_i  input  SW  Operands from requester 0/1.
REQ-007 req0_ready_o / req1_ready_o  output  1  Requester 0/1 handshake accepted this cycle.
REQ-008 mul_a_o, mul_b_o  output  SW  Registered operands driven to the shared KOA multiplier.
REQ-009 mul_load_o  output  1  Load strobe to the multiplier's result register.
REQ-010 mul_result_i  input  2*SW  Registered product returned by the multiplier.
REQ-011 rsp_valid_o  output  1  Response available.
REQ-012 rsp_id_o  output  1  Index of the requester that owns the response.
REQ-013 rsp_result_o  output  2*SW  Product, equal to mul_result_i.
REQ-014 rsp_ready_i  input  1  Consumer accepts the response.

Function
REQ-015 The block SHALL implement the FSM states IDLE, BUSY and DONE, with one operation outstanding at most.
REQ-016 In IDLE, the block SHALL assert the ready of exactly one requester (the grant) when at least one valid is high; it SHALL deassert both readies in BUSY and DONE.
REQ-017 A grant in IDLE SHALL latch the granted operands into mul_a_o/mul_b_o, latch the id, load the counter with LAT-1, and move the FSM to BUSY.
REQ-018 BUSY SHALL last exactly LAT cycles; mul_load_o SHALL be high only in the final BUSY cycle, after which the FSM moves to DONE.
REQ-019 DONE SHALL assert rsp_valid_o, hold rsp_id_o, and hold mul_a_o/mul_b_o stable; the FSM SHALL return to IDLE on the cycle where rsp_ready_i is high.
REQ-020 Latency from the accept edge to the first rsp_valid_o cycle SHALL be LAT+1 cycles.
REQ-021 The block SHALL hold DONE indefinitely while rsp_ready_i is low, with no new accepts.
REQ-022 Back-to-back throughput SHALL be one operation per LAT+2 cycles: after a DONE/IDLE transition, IDLE SHALL last at least one cycle.
REQ-023 Operand and result widths SHALL be passed through unmodified, with no truncation.

Reset
REQ-024 While rst is low, the FSM SHALL be IDLE, the counter 0, mul_a_o/mul_b_o 0, mul_load_o 0, rsp_valid_o 0, rsp_id_o 0, both readies 0, and the priority pointer set to requester 0.
REQ-025 A reset in BUSY or DONE SHALL abort the operation silently, emitting no response.

Configuration
REQ-026 With macro KOA_SCHED_ROUND_ROBIN_EN defined, simultaneous valids SHALL be granted to the requester not served last; the pointer SHALL update on each grant.
REQ-027 Without KOA_SCHED_ROUND_ROBIN_EN, requester 0 SHALL always win a tie, and no pointer flop SHALL exist.

Structure
REQ-028 A shared package koa_sched_pkg SHALL hold the FSM state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2) and the constant for the counter width (4 bits).
REQ-029 Grant logic SHALL be a sub-module koa_sched_arb: its inputs are the two valids, the pointer and an enable; its output is a one-hot grant.

Verification
REQ-030 Test LAT=2 single request: req0 valid with a=3, b=5 accepted at cycle t -> mul_load_o high at t+2, rsp_valid_o high at t+3, rsp_id_o=0, rsp_result_o=15.
REQ-031 Test simultaneous valids for 4 operations with the round-robin macro -> grant order 0,1,0,1; without the macro -> order 0,0,0,0.
REQ-032 Test backpressure: rsp_ready_i low for 10 cycles in DONE -> rsp_valid_o stays high, the result stays stable, and both readies stay 0.
REQ-033 Test reset mid-BUSY: rst low in the first BUSY cycle -> all outputs return to reset values and no rsp_valid_o pulse appears.
REQ-034 Test LAT=1 with max operands a=b=2^SW-1 -> mul_load_o is a one-cycle pulse in BUSY and rsp_result_o=(2^SW-1)^2 two cycles after the accept.
